decoder_scan_nto2n: RTL and testbench

Parametrised N-to-2^N decoder with registered, active-low one-cold outputs. It is the successor of the lab's 2-to-4 active-low decoder.
Adds enable/blanking, a direct-decode mode and an autonomous scan mode. In scan mode an internal prescaled counter sweeps the active output over a programmable range, for multiplexed display digit strobes and bank selects.
Sits between control logic or a display driver and the strobe or select lines of the target.

---
 rtl/decoder_scan_nto2n.sv | 85 ++++++++
 tb/tb_decoder_scan_nto2n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: parametrised N-to-2^N decoder with registered,
// active-low one-cold outputs. Direct mode decodes sel; scan mode sweeps
// the active output over 0..scan_last, one step every SCAN_DIV cycles.
module decoder_scan_nto2n #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic [N-1:0]      scan_last,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      idx,
  output logic              tick
);

  localparam int OUTS = 2**N;
  // Prescaler needs at least one bit even when SCAN_DIV = 1.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  // Registered copy of mode; only used to detect entry into scan mode.
  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [N-1:0]    idx_next;
  logic            tick_next;
  logic [OUTS-1:0] y_next;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_DIRECT;
      presc_reg <= '0;
      idx       <= '0;
      tick      <= 1'b0;
      Y         <= '1;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      idx       <= idx_next;
      tick      <= tick_next;
      Y         <= y_next;
    end
  end

  // Next-state logic: direct decode, scan entry, frozen scan, scan step.
  always_comb begin
    state_next = mode ? ST_SCAN : ST_DIRECT;
    idx_next   = idx;
    presc_next = presc_reg;
    tick_next  = 1'b0;
    if (!mode) begin
      idx_next   = sel;
      presc_next = '0;
    end else if (state_reg == ST_DIRECT) begin
      // First scan cycle restarts the sweep from index 0.
      idx_next   = '0;
      presc_next = '0;
    end else if (en) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        // Out-of-range index (scan_last lowered mid-scan) also wraps to 0.
        idx_next   = (idx >= scan_last) ? '0 : idx + N'(1);
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  // One-cold decode of the upcoming index; blanked when en is low.
  generate
    for (genvar gi = 0; gi < OUTS; gi++) begin : g_dec
      assign y_next[gi] = ~(en & (idx_next == N'(gi)));
    end
  endgenerate

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Self-checking bench for decoder_scan_nto2n: two instances (SCAN_DIV = 3
// and SCAN_DIV = 1) driven by directed steps, scoreboarded against a
// behavioural model plus fixed expected sequences.
module tb_decoder_scan_nto2n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en, mode;
  logic [1:0] sel, scan_last;
  logic [3:0] y;
  logic [1:0] idx;
  logic       tick;

  logic       en1, mode1;
  logic [1:0] sel1, scan_last1;
  logic [3:0] y1;
  logic [1:0] idx1;
  logic       tick1;

  decoder_scan_nto2n #(.N(2), .SCAN_DIV(3)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .scan_last(scan_last), .Y(y), .idx(idx), .tick(tick)
  );

  decoder_scan_nto2n #(.N(2), .SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .mode(mode1), .sel(sel1),
    .scan_last(scan_last1), .Y(y1), .idx(idx1), .tick(tick1)
  );

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state for each instance.
  logic [1:0] m0_idx, m1_idx;
  int         m0_pre, m1_pre;
  logic       m0_mq,  m1_mq;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one clock edge.
  task automatic model(input int div, input logic e, input logic md,
                       input logic [1:0] s, input logic [1:0] sl,
                       input logic [1:0] ci, input int cp, input logic cq,
                       output logic [1:0] ni, output int np, output logic nq,
                       output exp_t ex);
    logic t;
    t  = 1'b0;
    ni = ci;
    np = cp;
    if (!md) begin
      ni = s;
      np = 0;
    end else if (!cq) begin
      ni = 2'd0;
      np = 0;
    end else if (e) begin
      if (cp == div - 1) begin
        np = 0;
        t  = 1'b1;
        ni = (ci >= sl) ? 2'd0 : ci + 2'd1;
      end else begin
        np = cp + 1;
      end
    end
    nq     = md;
    ex.idx = ni;
    ex.tick = t;
    ex.y   = e ? ~(4'b0001 << ni) : 4'b1111;
  endtask

  task automatic model_reset();
    m0_idx = 2'd0; m0_pre = 0; m0_mq = 1'b0;
    m1_idx = 2'd0; m1_pre = 0; m1_mq = 1'b0;
  endtask

  // One transaction: push model expectations, clock, pop and compare.
  task automatic cycle();
    exp_t e0, e1, g0, g1;
    model(3, en, mode, sel, scan_last, m0_idx, m0_pre, m0_mq, m0_idx, m0_pre, m0_mq, e0);
    model(1, en1, mode1, sel1, scan_last1, m1_idx, m1_pre, m1_mq, m1_idx, m1_pre, m1_mq, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    cyc++;
    g0 = q0.pop_front();
    g1 = q1.pop_front();
    $display("cyc %0d: dut Y=%b idx=%0d tick=%b | dut1 Y=%b idx=%0d tick=%b",
             cyc, y, idx, tick, y1, idx1, tick1);
    check("sb0", {1'b0, y, idx, tick}, {1'b0, g0.y, g0.idx, g0.tick});
    check("sb1", {1'b0, y1, idx1, tick1}, {1'b0, g1.y, g1.idx, g1.tick});
    check("onecold0", 8'($countones(~y) <= 1), 8'd1);
  endtask

  logic [1:0] exp_idx2 [14];
  logic       exp_tick2 [14];
  logic [3:0] exp_y1 [4];

  initial begin
    reset = 1'b1;
    en = 1'b0; mode = 1'b0; sel = 2'd0; scan_last = 2'd0;
    en1 = 1'b1; mode1 = 1'b0; sel1 = 2'd0; scan_last1 = 2'd0;
    model_reset();
    #12;
    check("reset_y", {4'b0, y}, 8'h0F);
    check("reset_idx", {6'b0, idx}, 8'h00);
    check("reset_tick", {7'b0, tick}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: direct decode.
    exp_y1 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      cycle();
      check("t1_y", {4'b0, y}, {4'b0, exp_y1[i]});
      check("t1_idx", {6'b0, idx}, 8'(i));
      check("t1_tick", {7'b0, tick}, 8'h00);
    end

    // Test 2: scan entry and full sweep, SCAN_DIV = 3.
    exp_idx2  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
    exp_tick2 = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    scan_last = 2'd3;
    mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("t2_idx", {6'b0, idx}, {6'b0, exp_idx2[i]});
      check("t2_tick", {7'b0, tick}, {7'b0, exp_tick2[i]});
    end

    // Test 3: reach idx 3, then lower scan_last to 1.
    for (int i = 0; i < 8; i++) cycle();
    check("t3_at3", {6'b0, idx}, 8'd3);
    scan_last = 2'd1;
    for (int i = 0; i < 3; i++) cycle();
    check("t3_wrap", {4'b0, y}, 8'h0E);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("t3_no2", 8'(idx == 2'd2), 8'd0);
    end
    check("t3_end", {6'b0, idx}, 8'd1);

    // Test 4: blank mid-scan at idx 2, prescaler 1.
    scan_last = 2'd3;
    for (int i = 0; i < 4; i++) cycle();
    check("t4_at2", {6'b0, idx}, 8'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_blank", {4'b0, y}, 8'h0F);
      check("t4_hold", {6'b0, idx}, 8'd2);
    end
    en = 1'b1;
    cycle();
    check("t4_resume", {6'b0, idx}, 8'd2);
    cycle();
    check("t4_step", {5'b0, idx, tick}, {5'b0, 2'd3, 1'b1});

    // Test 5: asynchronous reset mid-cycle during scan at idx 3.
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("t5_y", {4'b0, y}, 8'h0F);
    check("t5_idx", {6'b0, idx}, 8'h00);
    check("t5_tick", {7'b0, tick}, 8'h00);
    check("t5_y1", {4'b0, y1}, 8'h0F);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_wait", {5'b0, idx, tick}, 8'h00);
    end
    cycle();
    check("t5_first", {5'b0, idx, tick}, {5'b0, 2'd1, 1'b1});

    // Test 6: SCAN_DIV = 1 with scan_last = 0, then back to direct.
    mode1 = 1'b1;
    cycle();
    check("t6_entry", {7'b0, tick1}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t6_scan", {3'b0, y1, tick1}, {3'b0, 4'b1110, 1'b1});
    end
    mode1 = 1'b0;
    sel1 = 2'd2;
    cycle();
    check("t6_exit", {3'b0, y1, tick1}, {3'b0, 4'b1011, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
